// File: rtl/inst_fetcher.sv
// Front-end fetch unit: holds the fetch PC and looks it up in a direct-mapped,
// one-word-per-line instruction cache. Misses are refilled from the memory controller.
module inst_fetcher #(
    parameter int unsigned ICACHE_IDX_BIT = 4,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc,
    output logic        inst_valid,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    input  logic        f_ok,
    input  logic [31:0] f_next_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);

    localparam int unsigned Lines = 2 ** ICACHE_IDX_BIT;
    localparam int unsigned TagW  = 30 - ICACHE_IDX_BIT;

    typedef enum logic {
        StRun,
        StFetch
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       fill_addr_q, fill_addr_d;
    logic              fill_we;
    logic [Lines-1:0]  valid_q;
    logic [TagW-1:0]   tag_q  [Lines];
    logic [31:0]       data_q [Lines];

    logic [ICACHE_IDX_BIT-1:0] idx, fill_idx;
    logic [TagW-1:0]           pc_tag;
    logic                      hit;
    logic                      unused_low_bits;

    assign idx      = pc_q[ICACHE_IDX_BIT+1:2];
    assign pc_tag   = pc_q[31:ICACHE_IDX_BIT+2];
    assign fill_idx = fill_addr_q[ICACHE_IDX_BIT+1:2];
    assign hit      = valid_q[idx] && (tag_q[idx] == pc_tag);

    // Incoming PCs are forced word-aligned; their byte-offset bits are dropped.
    assign unused_low_bits = ^{f_next_pc[1:0], rob_new_pc[1:0]};

    assign inst_valid = (state_q == StRun) && hit && !rob_clear;
    assign inst_addr  = pc_q;
    assign inst_data  = data_q[idx];
    assign mem_req    = (state_q == StFetch);
    assign mem_addr   = fill_addr_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fill_addr_d = fill_addr_q;
        fill_we     = 1'b0;
        if (rdy_in) begin
            unique case (state_q)
                StRun: begin
                    // A flush in a miss cycle skips the refill of the abandoned PC.
                    if (!rob_clear) begin
                        if (!hit) begin
                            fill_addr_d = {pc_q[31:2], 2'b00};
                            state_d     = StFetch;
                        end else if (f_ok) begin
                            pc_d = {f_next_pc[31:2], 2'b00};
                        end
                    end
                end
                StFetch: begin
                    if (mem_done) begin
                        fill_we = 1'b1;
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
            if (rob_clear) begin
                pc_d = {rob_new_pc[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            fill_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fill_addr_q <= fill_addr_d;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset; valid bits gate every use.
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_addr_q[31:ICACHE_IDX_BIT+2];
            data_q[fill_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed vector table, a reset-mid-fetch
// sequence, then randomized traffic against a line-address cache model.
module tb_inst_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic [31:0] rob_new_pc;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        f_ok;
    logic [31:0] f_next_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    int n_vec = 0;
    int n_err = 0;

    inst_fetcher #(
        .ICACHE_IDX_BIT(4),
        .RESET_PC      (32'h0)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .rob_clear (rob_clear),
        .rob_new_pc(rob_new_pc),
        .inst_valid(inst_valid),
        .inst_addr (inst_addr),
        .inst_data (inst_data),
        .f_ok      (f_ok),
        .f_next_pc (f_next_pc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_done  (mem_done),
        .mem_data  (mem_data)
    );

    always #5 clk_in = ~clk_in;

    // Read-only instruction memory contents; address 0 holds 32'h13.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13;
    endfunction

    assign mem_data = mem_word(mem_addr);

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    typedef struct {
        logic        ev;
        logic [31:0] ea;
        logic        er;
        logic [31:0] ema;
        logic        fok;
        logic [31:0] fnpc;
        logic        md;
        logic        rc;
        logic [31:0] rpc;
        logic        rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic ev, input logic [31:0] ea, input logic er,
                                input logic [31:0] ema, input logic fok = 1'b0,
                                input logic [31:0] fnpc = 32'h0, input logic md = 1'b0,
                                input logic rc = 1'b0, input logic [31:0] rpc = 32'h0,
                                input logic rdy = 1'b1);
        vec_t v;
        v.ev = ev; v.ea = ea; v.er = er; v.ema = ema; v.fok = fok; v.fnpc = fnpc;
        v.md = md; v.rc = rc; v.rpc = rpc; v.rdy = rdy;
        tbl.push_back(v);
    endfunction

    // Reference model: cache holds full line addresses, fetch state is a pending flag.
    logic        m_fetch;
    logic [31:0] m_pc;
    logic [31:0] m_fill;
    logic        c_valid [16];
    logic [31:0] c_line  [16];

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic logic m_hit();
        return c_valid[line_of(m_pc)] && (c_line[line_of(m_pc)] == m_pc);
    endfunction

    function automatic void model_reset();
        m_fetch = 1'b0;
        m_pc    = 32'h0;
        m_fill  = 32'h0;
        for (int i = 0; i < 16; i++) begin
            c_valid[i] = 1'b0;
            c_line[i]  = 32'h0;
        end
    endfunction

    function automatic void model_edge();
        logic [31:0] next_pc;
        next_pc = m_pc;
        if (!rdy_in) return;
        if (m_fetch) begin
            if (mem_done) begin
                c_valid[line_of(m_fill)] = 1'b1;
                c_line[line_of(m_fill)]  = m_fill;
                m_fetch = 1'b0;
            end
        end else if (!rob_clear) begin
            if (!m_hit()) begin
                m_fill  = m_pc;
                m_fetch = 1'b1;
            end else if (f_ok) begin
                next_pc = f_next_pc & ~32'h3;
            end
        end
        if (rob_clear) next_pc = rob_new_pc & ~32'h3;
        m_pc = next_pc;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 32'h7FF));
    endfunction

    initial begin
        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        rob_clear  = 1'b0;
        rob_new_pc = 32'h0;
        f_ok       = 1'b0;
        f_next_pc  = 32'h0;
        mem_done   = 1'b0;

        // Cold start, sequential fills, hit loop 4/8/0/4
        add(0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 4; i++) add(0, 32'h0, 1, 32'h0);
        add(0, 32'h0, 1, 32'h0, 0, 0, 1);
        add(1, 32'h0, 0, 0, 1, 32'h4);
        add(0, 32'h4, 0, 0);
        add(0, 32'h4, 1, 32'h4, 0, 0, 1);
        add(1, 32'h4, 0, 0, 1, 32'h8);
        add(0, 32'h8, 0, 0);
        add(0, 32'h8, 1, 32'h8, 0, 0, 1);
        add(1, 32'h8, 0, 0, 1, 32'h0);
        add(1, 32'h0, 0, 0, 1, 32'h4);
        add(1, 32'h4, 0, 0, 1, 32'h8);
        add(1, 32'h8, 0, 0, 1, 32'h0);
        // Back-pressure, then a frozen cycle that must ignore f_ok
        for (int i = 0; i < 5; i++) add(1, 32'h0, 0, 0);
        add(1, 32'h0, 0, 0, 1, 32'h40, 0, 0, 0, 0);
        // Alias eviction of index 0
        add(1, 32'h0, 0, 0, 1, 32'h40);
        add(0, 32'h40, 0, 0);
        add(0, 32'h40, 1, 32'h40, 0, 0, 1);
        add(1, 32'h40, 0, 0, 1, 32'h0);
        add(0, 32'h0, 0, 0);
        add(0, 32'h0, 1, 32'h0, 0, 0, 1);
        // Flush during a miss: fill for 0x100 completes, then 0x200 is fetched
        add(1, 32'h0, 0, 0, 1, 32'h100);
        add(0, 32'h100, 0, 0);
        add(0, 32'h100, 1, 32'h100, 0, 0, 0, 1, 32'h200);
        add(0, 32'h200, 1, 32'h100);
        add(0, 32'h200, 1, 32'h100, 0, 0, 1);
        add(0, 32'h200, 0, 0);
        add(0, 32'h200, 1, 32'h200, 0, 0, 1);
        add(1, 32'h200, 0, 0);
        // Clear beats f_ok on a hit cycle
        add(0, 32'h200, 0, 0, 1, 32'h10, 0, 1, 32'h80);
        add(0, 32'h80, 0, 0);
        // mem_done coincident with clear: fill lands and pc redirects together
        add(0, 32'h80, 1, 32'h80, 0, 0, 1, 1, 32'h0);
        add(0, 32'h0, 0, 0);
        add(0, 32'h0, 1, 32'h0, 0, 0, 1);
        add(1, 32'h0, 0, 0);

        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        foreach (tbl[i]) begin
            rdy_in     = tbl[i].rdy;
            rob_clear  = tbl[i].rc;
            rob_new_pc = tbl[i].rpc;
            f_ok       = tbl[i].fok;
            f_next_pc  = tbl[i].fnpc;
            mem_done   = tbl[i].md;
            @(negedge clk_in);
            chk($sformatf("t%0d.inst_valid", i), 32'(inst_valid), 32'(tbl[i].ev));
            chk($sformatf("t%0d.inst_addr", i), inst_addr, tbl[i].ea);
            if (tbl[i].ev) chk($sformatf("t%0d.inst_data", i), inst_data, mem_word(tbl[i].ea));
            chk($sformatf("t%0d.mem_req", i), 32'(mem_req), 32'(tbl[i].er));
            if (tbl[i].er) chk($sformatf("t%0d.mem_addr", i), mem_addr, tbl[i].ema);
            @(posedge clk_in);
            #1;
        end
        rob_clear = 1'b0;
        mem_done  = 1'b0;

        // Reset asserted mid-FETCH drops the request without waiting for a clock
        f_ok      = 1'b1;
        f_next_pc = 32'h300;
        @(posedge clk_in);
        #1 f_ok = 1'b0;
        @(posedge clk_in);
        #1;
        chk("pre_reset.mem_req", 32'(mem_req), 32'h1);
        chk("pre_reset.mem_addr", mem_addr, 32'h300);
        #2 rst_in = 1'b1;
        #1;
        chk("async_reset.mem_req", 32'(mem_req), 32'h0);
        chk("async_reset.inst_addr", inst_addr, 32'h0);
        chk("async_reset.inst_valid", 32'(inst_valid), 32'h0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Randomized traffic; the first cycle carries a late mem_done that RUN must ignore
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 0) begin
                rdy_in    = 1'b1;
                rob_clear = 1'b0;
                f_ok      = 1'b0;
                mem_done  = 1'b1;
            end else begin
                rdy_in     = ($urandom_range(9) != 0);
                rob_clear  = ($urandom_range(19) == 0);
                rob_new_pc = rand_addr();
                f_ok       = ($urandom_range(9) < 7);
                f_next_pc  = ($urandom_range(9) < 7) ? (m_pc + 32'h4) | 32'($urandom_range(3))
                                                     : rand_addr();
                mem_done   = rdy_in && mem_req && ($urandom_range(2) == 0);
            end
            @(negedge clk_in);
            chk("rnd.inst_valid", 32'(inst_valid), 32'(!m_fetch && m_hit() && !rob_clear));
            chk("rnd.inst_addr", inst_addr, m_pc);
            if (!m_fetch && m_hit()) chk("rnd.inst_data", inst_data, mem_word(m_pc));
            chk("rnd.mem_req", 32'(mem_req), 32'(m_fetch));
            if (m_fetch) chk("rnd.mem_addr", mem_addr, m_fill);
            @(posedge clk_in);
            model_edge();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
